// File: rtl/seg7_digit_mux.sv
// Eight-digit multiplexed 7-segment driver with a double-buffered display value.
// A new value is staged in a pending register and committed only at a frame wrap.
module seg7_digit_mux #(
    parameter int COMMON_ANODE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  digit_sel,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_dp,
    input  logic        blank_lz,
    output logic        load_ready,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam logic [7:0] AN_POL  = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;
    localparam logic [6:0] SEG_POL = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_POL  = (COMMON_ANODE != 0) ? 1'b1  : 1'b0;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [31:0] active_data_r;
    logic [7:0]  active_dp_r;
    logic [31:0] pend_data_r;
    logic [7:0]  pend_dp_r;
    logic        pend_valid_r;
    logic [2:0]  prev_sel_r;
    logic        load_ready_r;
    logic        frame_start_r;
    logic [7:0]  an_r;
    logic [6:0]  seg_r;
    logic        dp_r;

    logic        wrap_s;
    logic        xfer_s;
    logic [31:0] active_data_nxt_s;
    logic [7:0]  active_dp_nxt_s;
    logic [31:0] pend_data_nxt_s;
    logic [7:0]  pend_dp_nxt_s;
    logic        pend_valid_nxt_s;
    logic        zero_run_s;
    logic [7:0]  blank_mask_s;
    logic [3:0]  sel_nib_s;
    logic [6:0]  seg_hi_s;
    logic [7:0]  an_hi_s;
    logic        dp_hi_s;

    // Frame-wrap detection, producer handshake and pending-to-active commit.
    always_comb begin
        wrap_s            = (prev_sel_r == 3'd7) && (digit_sel == 3'd0);
        xfer_s            = load_valid && load_ready_r;
        active_data_nxt_s = active_data_r;
        active_dp_nxt_s   = active_dp_r;
        pend_data_nxt_s   = pend_data_r;
        pend_dp_nxt_s     = pend_dp_r;
        pend_valid_nxt_s  = pend_valid_r;
        // load_ready is low whenever pending is full, so a commit and a
        // transfer can never coincide.
        if (wrap_s && pend_valid_r) begin
            active_data_nxt_s = pend_data_r;
            active_dp_nxt_s   = pend_dp_r;
            pend_valid_nxt_s  = 1'b0;
        end else if (xfer_s) begin
            pend_data_nxt_s  = load_data;
            pend_dp_nxt_s    = load_dp;
            pend_valid_nxt_s = 1'b1;
        end else begin
            pend_valid_nxt_s = pend_valid_r;
        end
    end

    // Leading-zero mask: digit k is blankable when nibbles k..7 are all zero.
    always_comb begin
        zero_run_s   = 1'b1;
        blank_mask_s = 8'h00;
        for (int k = 7; k >= 1; k--) begin
            zero_run_s      = zero_run_s & (active_data_nxt_s[4*k +: 4] == 4'h0);
            blank_mask_s[k] = zero_run_s;
        end
    end

    // Active-high digit drive; decodes from the post-commit value so a new
    // frame starts with the new value already on digit 0.
    always_comb begin
        sel_nib_s = active_data_nxt_s[{digit_sel, 2'b00} +: 4];
        an_hi_s   = 8'h01 << digit_sel;
        dp_hi_s   = active_dp_nxt_s[digit_sel];
        if (blank_lz && blank_mask_s[digit_sel]) begin
            seg_hi_s = 7'h00;
        end else begin
            seg_hi_s = seg_decode(sel_nib_s);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_data_r <= 32'h0000_0000;
            active_dp_r   <= 8'h00;
            pend_data_r   <= 32'h0000_0000;
            pend_dp_r     <= 8'h00;
            pend_valid_r  <= 1'b0;
            prev_sel_r    <= 3'd0;
            load_ready_r  <= 1'b0;
            frame_start_r <= 1'b0;
            an_r          <= AN_POL;
            seg_r         <= SEG_POL;
            dp_r          <= DP_POL;
        end else begin
            active_data_r <= active_data_nxt_s;
            active_dp_r   <= active_dp_nxt_s;
            pend_data_r   <= pend_data_nxt_s;
            pend_dp_r     <= pend_dp_nxt_s;
            pend_valid_r  <= pend_valid_nxt_s;
            prev_sel_r    <= digit_sel;
            load_ready_r  <= ~pend_valid_nxt_s;
            frame_start_r <= wrap_s;
            an_r          <= an_hi_s ^ AN_POL;
            seg_r         <= seg_hi_s ^ SEG_POL;
            dp_r          <= dp_hi_s ^ DP_POL;
        end
    end

    assign load_ready  = load_ready_r;
    assign frame_start = frame_start_r;
    assign an          = an_r;
    assign seg         = seg_r;
    assign dp          = dp_r;

endmodule

// File: doc/seg7_digit_mux.md
SEG7_DIGIT_MUX -- requirements
Module: seg7_digit_mux

Interface
REQ-001 Parameter COMMON_ANODE, default 1: 1 = an/seg/dp active-low; 0 = active-high.
REQ-002 clock  input  1  single system clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 digit_sel  input  3  current refresh digit index from the upstream 3-bit refresh counter.
REQ-005 load_valid  input  1  producer offers a new display value.
REQ-006 load_data  input  32  eight hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
REQ-007 load_dp  input  8  decimal point per digit, bit k = digit k, 1 = lit.
REQ-008 blank_lz  input  1  1 = blank leading-zero digits; sampled continuously.
REQ-009 load_ready  output  1  block can accept a value this cycle.
REQ-010 an  output  8  digit enables, one-hot (active level per COMMON_ANODE).
REQ-011 seg  output  7  segments, bit0 = a ... bit6 = g.
REQ-012 dp  output  1  decimal point of the enabled digit.
REQ-013 frame_start  output  1  one-cycle pulse marking a frame boundary.

Function
REQ-014 Block SHALL hold an active register (32-bit data, 8-bit dp) and a pending register with a pending_valid flag.
REQ-015 load_ready SHALL equal NOT pending_valid, registered; transfer occurs on a cycle with load_valid=1 and load_ready=1.
REQ-016 On transfer, load_data/load_dp SHALL be captured into pending and pending_valid SHALL be 1 from the next cycle.
REQ-017 Block SHALL register digit_sel as prev_sel every cycle; a wrap is prev_sel=7 and digit_sel=0; no other transition is a wrap.
REQ-018 On a wrap with pending_valid=1, pending SHALL copy into active and pending_valid SHALL clear at the same edge.
REQ-019 On a wrap with pending_valid=0, active SHALL be unchanged; a transfer on that same cycle is captured into pending and commits at the next wrap only.
REQ-020 Active SHALL never change except at a wrap (no tearing within a frame).
REQ-021 frame_start SHALL be 1 for exactly the cycle following each wrap, independent of pending_valid.
REQ-022 an, seg, dp SHALL be registered, reflecting digit_sel and the active register with latency of 1 cycle.
REQ-023 an SHALL enable exactly bit digit_sel; all other bits inactive.
REQ-024 seg SHALL decode the selected nibble, active-high patterns (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-025 With COMMON_ANODE=1, an, seg and dp SHALL be bitwise inverted from active-high values.
REQ-026 Digit k (k>=1) SHALL be blanked (all segments off, an still enabled) when blank_lz=1 and nibbles k..7 of active are all zero; digit 0 is never blanked.
REQ-027 dp SHALL equal active dp bit digit_sel, regardless of blanking.
REQ-028 Arbitrary digit_sel jumps SHALL be displayed correctly with no state corruption.

Reset
REQ-029 While reset=1: active data and dp = 0, pending cleared, pending_valid=0, prev_sel=0, load_ready=0, frame_start=0.
REQ-030 While reset=1: an, seg, dp inactive (COMMON_ANODE=1: an=FF, seg=7F, dp=1).
REQ-031 load_ready SHALL be 1 the first cycle after reset deasserts; reset mid-transfer discards pending.

Verification
REQ-032 Reset, then digit_sel cycling 0..7, COMMON_ANODE=1 -> an=FE,FD,...,7F one cycle late; seg=40 (digit "0") each digit; blank_lz=1 -> digits 1..7 seg=7F.
REQ-033 Load 0x89ABCDEF, dp=0x01 mid-frame at digit_sel=3 -> load_ready drops next cycle; display unchanged until wrap; frame_start pulse; digit0 then seg=0E (F), dp=0.
REQ-034 Two back-to-back load attempts while pending_valid=1 -> second held off (load_ready=0), accepted only after commit; final display = second value.
REQ-035 Active 0x00000120, blank_lz=1 -> digits 3..7 blank, digit 2 = "1", digit 1 = "2", digit 0 = "0".
REQ-036 Assert reset during pending_valid=1 -> pending dropped, after reset all digits show "0", load_ready=1.
